// File: rtl/data_mem_controller.sv
// Load/store responder between the load-store buffer and the memory arbiter.
// Serialises one request at a time onto a byte-wide little-endian memory/IO bus.
module data_mem_controller #(
  parameter int unsigned ADDR_WIDTH = 18,
  parameter logic [1:0]  IO_TAG     = 2'b11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dcache_rw_en,
  input  logic                  dcache_write_mode,
  input  logic [1:0]            dcache_width,
  input  logic                  dcache_sign_ext,
  input  logic [ADDR_WIDTH-1:0] dcache_addr,
  input  logic [31:0]           dcache_value,
  output logic                  dcache_idle,
  output logic                  dcache_rw_feedback_en,
  output logic [31:0]           dcache_load_val,
  output logic                  mem_busy,
  input  logic                  mem_grant,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  input  logic                  io_buffer_full
);

  typedef enum logic [1:0] {StIdle, StGnt, StRd, StWr} state_e;

  state_e                state_q, state_d;
  logic                  write_q, write_d;
  logic [1:0]            width_q, width_d;
  logic                  sext_q, sext_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           value_q, value_d;
  logic [2:0]            issue_q, issue_d;  // bytes put on the bus so far
  logic [2:0]            capt_q, capt_d;    // load bytes captured so far
  logic [31:0]           lanes_q, lanes_d;
  logic                  fb_q, fb_d;
  logic [31:0]           load_val_q, load_val_d;

  logic [2:0]  nbytes;
  logic        accept;
  logic        io_stall;
  logic        last_issue;
  logic [7:0]  store_byte;
  logic [31:0] merged;
  logic [31:0] extended;

  always_comb begin
    unique case (width_q)
      2'd0:    nbytes = 3'd1;
      2'd1:    nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
  end

  assign accept     = dcache_rw_en && ((state_q == StIdle) || fb_q);
  assign io_stall   = write_q && (addr_q[ADDR_WIDTH-1 -: 2] == IO_TAG) && io_buffer_full;
  assign last_issue = (issue_q == nbytes - 3'd1);
  assign store_byte = value_q[{issue_q[1:0], 3'b000} +: 8];

  // Final load byte arrives straight from the bus in the completing cycle.
  always_comb begin
    merged = lanes_q;
    merged[{capt_q[1:0], 3'b000} +: 8] = mem_din;
  end

  always_comb begin
    unique case (width_q)
      2'd0:    extended = {{24{sext_q & merged[7]}}, merged[7:0]};
      2'd1:    extended = {{16{sext_q & merged[15]}}, merged[15:0]};
      default: extended = merged;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    width_d    = width_q;
    sext_d     = sext_q;
    addr_d     = addr_q;
    value_d    = value_q;
    issue_d    = issue_q;
    capt_d     = capt_q;
    lanes_d    = lanes_q;
    fb_d       = 1'b0;
    load_val_d = load_val_q;
    mem_a      = '0;
    mem_wr     = 1'b0;
    mem_dout   = 8'h00;

    unique case (state_q)
      StIdle: ;
      StGnt: begin
        if (mem_grant && !io_stall) begin
          mem_a    = addr_q + ADDR_WIDTH'(issue_q);
          mem_wr   = write_q;
          mem_dout = write_q ? store_byte : 8'h00;
          issue_d  = issue_q + 3'd1;
          state_d  = write_q ? StWr : StRd;
          fb_d     = write_q && last_issue;
        end
      end
      StRd: begin
        if (fb_q) begin
          state_d = StIdle;
        end else begin
          lanes_d = merged;
          capt_d  = capt_q + 3'd1;
          if (issue_q < nbytes) begin
            mem_a   = addr_q + ADDR_WIDTH'(issue_q);
            issue_d = issue_q + 3'd1;
          end
          if (capt_q == nbytes - 3'd1) begin
            fb_d       = 1'b1;
            load_val_d = extended;
          end
        end
      end
      StWr: begin
        if (fb_q) begin
          state_d = StIdle;
        end else if (!io_stall) begin
          mem_a    = addr_q + ADDR_WIDTH'(issue_q);
          mem_wr   = 1'b1;
          mem_dout = store_byte;
          issue_d  = issue_q + 3'd1;
          fb_d     = last_issue;
        end
      end
      default: state_d = StIdle;
    endcase

    // Acceptance only happens in idle or in the feedback cycle, where no bus traffic occurs.
    if (accept) begin
      state_d = StGnt;
      write_d = dcache_write_mode;
      width_d = dcache_width;
      sext_d  = dcache_sign_ext;
      addr_d  = dcache_addr;
      value_d = dcache_value;
      issue_d = 3'd0;
      capt_d  = 3'd0;
      lanes_d = 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      write_q    <= 1'b0;
      width_q    <= 2'd0;
      sext_q     <= 1'b0;
      addr_q     <= '0;
      value_q    <= 32'h0;
      issue_q    <= 3'd0;
      capt_q     <= 3'd0;
      lanes_q    <= 32'h0;
      fb_q       <= 1'b0;
      load_val_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      write_q    <= write_d;
      width_q    <= width_d;
      sext_q     <= sext_d;
      addr_q     <= addr_d;
      value_q    <= value_d;
      issue_q    <= issue_d;
      capt_q     <= capt_d;
      lanes_q    <= lanes_d;
      fb_q       <= fb_d;
      load_val_q <= load_val_d;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && accept && (dcache_width == 2'b11)) begin
      $fatal(1, "data_mem_controller: illegal access width 2'b11");
    end
  end
`endif

  assign dcache_idle           = (state_q == StIdle);
  assign mem_busy              = (state_q != StIdle);
  assign dcache_rw_feedback_en = fb_q;
  assign dcache_load_val       = load_val_q;

endmodule

// File: tb/tb_data_mem_controller.sv
// Directed bench for data_mem_controller: vector table plus multi-cycle corner sequences,
// with a byte-addressed memory model driven from the same process.
module tb_data_mem_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        dcache_rw_en, dcache_write_mode, dcache_sign_ext;
  logic [1:0]  dcache_width;
  logic [17:0] dcache_addr;
  logic [31:0] dcache_value;
  logic        dcache_idle, dcache_rw_feedback_en;
  logic [31:0] dcache_load_val;
  logic        mem_busy, mem_grant, mem_wr, io_buffer_full;
  logic [7:0]  mem_din, mem_dout;
  logic [17:0] mem_a;

  data_mem_controller #(.ADDR_WIDTH(18), .IO_TAG(2'b11)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .dcache_rw_en          (dcache_rw_en),
    .dcache_write_mode     (dcache_write_mode),
    .dcache_width          (dcache_width),
    .dcache_sign_ext       (dcache_sign_ext),
    .dcache_addr           (dcache_addr),
    .dcache_value          (dcache_value),
    .dcache_idle           (dcache_idle),
    .dcache_rw_feedback_en (dcache_rw_feedback_en),
    .dcache_load_val       (dcache_load_val),
    .mem_busy              (mem_busy),
    .mem_grant             (mem_grant),
    .mem_din               (mem_din),
    .mem_dout              (mem_dout),
    .mem_a                 (mem_a),
    .mem_wr                (mem_wr),
    .io_buffer_full        (io_buffer_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [1:0]  width;
    logic        sext;
    logic [17:0] addr;
    logic [31:0] value;
    logic [31:0] pre;
    logic [31:0] exp_load;
    int          exp_fb;
  } vec_t;

  logic [7:0] mem [int];
  logic [7:0] next_din;
  int         wr_cnt;
  int         errors;
  int         checks;

  function automatic logic [7:0] rd(input logic [17:0] a);
    return mem.exists(int'(a)) ? mem[int'(a)] : 8'h00;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Advance one cycle; the memory returns the byte addressed last cycle.
  task automatic step(input logic g, input logic io);
    @(posedge clk);
    #1;
    mem_din        = next_din;
    mem_grant      = g;
    io_buffer_full = io;
    #1;
    if (mem_wr) begin
      mem[int'(mem_a)] = mem_dout;
      wr_cnt++;
    end
    next_din = rd(mem_a);
  endtask

  function automatic int nbytes(input logic [1:0] w);
    return (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
  endfunction

  task automatic preload(input vec_t v);
    logic [17:0] a;
    for (int k = 0; k < 4; k++) begin
      a = v.addr + 18'(k);
      mem[int'(a)] = v.pre[8*k +: 8];
    end
  endtask

  task automatic present(input vec_t v);
    dcache_rw_en      = 1'b1;
    dcache_write_mode = v.wr;
    dcache_width      = v.width;
    dcache_sign_ext   = v.sext;
    dcache_addr       = v.addr;
    dcache_value      = v.value;
  endtask

  task automatic do_op(input vec_t v, input int gdelay, output int fbc);
    int          n;
    int          k;
    logic [17:0] a;
    n   = nbytes(v.width);
    fbc = -1;
    present(v);
    step(gdelay == 0, 1'b0);
    dcache_rw_en = 1'b0;
    for (int cyc = 1; cyc <= 40 && fbc < 0; cyc++) begin
      if (cyc > gdelay && cyc <= gdelay + n) begin
        k = cyc - gdelay - 1;
        a = v.addr + 18'(k);
        chk("bus_addr", 32'(mem_a), 32'(a));
        chk("bus_wr", 32'(mem_wr), 32'(v.wr));
        if (v.wr) chk("bus_dout", 32'(mem_dout), 32'(v.value[8*k +: 8]));
      end else if (cyc <= gdelay) begin
        chk("nogrant_wr", 32'(mem_wr), 32'd0);
        chk("nogrant_addr", 32'(mem_a), 32'd0);
        chk("nogrant_busy", 32'(mem_busy), 32'd1);
      end
      if (dcache_rw_feedback_en) fbc = cyc;
      else step((cyc + 1) > gdelay, 1'b0);
    end
    if (fbc < 0) chk("fb_timeout", 32'd0, 32'd1);
  endtask

  vec_t vecs [9];
  vec_t v;
  vec_t st;
  int   fbc;
  int   w0;
  int   n;
  int   pulses;
  int   wrs;
  logic [17:0] a;

  initial begin
    errors = 0; checks = 0; wr_cnt = 0; next_din = 8'h00;
    dcache_rw_en = 0; dcache_write_mode = 0; dcache_width = 0; dcache_sign_ext = 0;
    dcache_addr = '0; dcache_value = '0; mem_grant = 1; mem_din = 0; io_buffer_full = 0;

    //             wr  width sext addr       value         pre           exp_load      fb
    vecs[0] = '{1'b0, 2'd2, 1'b0, 18'h00100, 32'h0,        32'h84332211, 32'h84332211, 6};
    vecs[1] = '{1'b0, 2'd0, 1'b1, 18'h00200, 32'h0,        32'h00000080, 32'hFFFFFF80, 3};
    vecs[2] = '{1'b0, 2'd0, 1'b0, 18'h00200, 32'h0,        32'h00000080, 32'h00000080, 3};
    vecs[3] = '{1'b0, 2'd1, 1'b1, 18'h3FFFF, 32'h0,        32'h000080FE, 32'hFFFF80FE, 4};
    vecs[4] = '{1'b0, 2'd1, 1'b0, 18'h00010, 32'h0,        32'h1234F00D, 32'h0000F00D, 4};
    vecs[5] = '{1'b1, 2'd1, 1'b0, 18'h3FFFF, 32'hABCD1234, 32'h0,        32'h0,        3};
    vecs[6] = '{1'b1, 2'd2, 1'b0, 18'h00050, 32'hDEADBEEF, 32'h0,        32'h0,        5};
    vecs[7] = '{1'b1, 2'd0, 1'b0, 18'h00007, 32'h0000005A, 32'h0,        32'h0,        2};
    vecs[8] = '{1'b0, 2'd2, 1'b1, 18'h2FFFE, 32'h0,        32'h01020304, 32'h01020304, 6};

    rst = 1'b1;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("rst_idle", 32'(dcache_idle), 32'd1);
    chk("rst_fb", 32'(dcache_rw_feedback_en), 32'd0);
    chk("rst_load_val", dcache_load_val, 32'd0);
    chk("rst_busy", 32'(mem_busy), 32'd0);
    chk("rst_bus", {mem_wr, 5'd0, mem_a, mem_dout}, 32'd0);
    rst = 1'b0;
    step(1'b1, 1'b0);

    for (int i = 0; i < 9; i++) begin
      v  = vecs[i];
      n  = nbytes(v.width);
      if (!v.wr) preload(v);
      w0 = wr_cnt;
      do_op(v, 0, fbc);
      chk("fb_cycle", 32'(fbc), 32'(v.exp_fb));
      if (!v.wr) chk("load_val", dcache_load_val, v.exp_load);
      step(1'b1, 1'b0);
      chk("fb_one_cycle", 32'(dcache_rw_feedback_en), 32'd0);
      chk("idle_after", 32'(dcache_idle), 32'd1);
      chk("write_count", 32'(wr_cnt - w0), v.wr ? 32'(n) : 32'd0);
      if (v.wr) begin
        for (int k = 0; k < n; k++) begin
          a = v.addr + 18'(k);
          chk("stored_byte", 32'(rd(a)), 32'(v.value[8*k +: 8]));
        end
      end
    end

    // IO store held off by a full IO buffer for three cycles.
    st = '{1'b1, 2'd0, 1'b0, 18'h30000, 32'h00000041, 32'h0, 32'h0, 0};
    w0 = wr_cnt; pulses = 0; fbc = -1;
    present(st);
    step(1'b1, 1'b1);
    dcache_rw_en = 1'b0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      if (cyc <= 3) chk("io_stall_wr", 32'(mem_wr), 32'd0);
      if (cyc == 4) chk("io_write", {mem_wr, 5'd0, mem_a, mem_dout}, {1'b1, 5'd0, 18'h30000, 8'h41});
      if (dcache_rw_feedback_en) begin
        pulses++;
        if (fbc < 0) fbc = cyc;
      end
      step(1'b1, (cyc + 1) <= 3);
    end
    chk("io_fb_cycle", 32'(fbc), 32'd5);
    chk("io_fb_pulses", 32'(pulses), 32'd1);
    chk("io_write_count", 32'(wr_cnt - w0), 32'd1);
    chk("io_byte", 32'(rd(18'h30000)), 32'h41);

    // Back-to-back: store presented during the load's feedback cycle.
    v  = vecs[0];
    st = '{1'b1, 2'd2, 1'b0, 18'h00400, 32'hCAFEF00D, 32'h0, 32'h0, 0};
    preload(v);
    present(v);
    step(1'b1, 1'b0);
    fbc = -1;
    for (int cyc = 1; cyc <= 20 && fbc < 0; cyc++) begin
      chk("b2b_busy_load", 32'(mem_busy), 32'd1);
      if (dcache_rw_feedback_en) fbc = cyc;
      else step(1'b1, 1'b0);
    end
    chk("b2b_load_fb", 32'(fbc), 32'd6);
    chk("b2b_load_val", dcache_load_val, 32'h84332211);
    chk("b2b_fb_idle", 32'(dcache_idle), 32'd0);
    present(st);
    step(1'b1, 1'b0);
    dcache_rw_en = 1'b0;
    fbc = -1;
    for (int cyc = 1; cyc <= 20 && fbc < 0; cyc++) begin
      chk("b2b_busy_store", 32'(mem_busy), 32'd1);
      if (dcache_rw_feedback_en) fbc = cyc;
      else step(1'b1, 1'b0);
    end
    chk("b2b_store_fb", 32'(fbc), 32'd5);
    step(1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      a = st.addr + 18'(k);
      chk("b2b_stored_byte", 32'(rd(a)), 32'(st.value[8*k +: 8]));
    end

    // Grant withheld for five cycles shifts the whole load by five.
    v = vecs[0];
    preload(v);
    do_op(v, 5, fbc);
    chk("gnt_fb_cycle", 32'(fbc), 32'd11);
    chk("gnt_load_val", dcache_load_val, 32'h84332211);
    step(1'b1, 1'b0);

    // Reset in the middle of a word load abandons it.
    preload(vecs[0]);
    present(vecs[0]);
    step(1'b1, 1'b0);
    dcache_rw_en = 1'b0;
    step(1'b1, 1'b0);
    rst = 1'b1;
    step(1'b1, 1'b0);
    rst = 1'b0;
    chk("midrst_idle", 32'(dcache_idle), 32'd1);
    chk("midrst_busy", 32'(mem_busy), 32'd0);
    pulses = 0; wrs = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (dcache_rw_feedback_en) pulses++;
      if (mem_wr || mem_a != 18'h0) wrs++;
      step(1'b1, 1'b0);
    end
    chk("midrst_no_fb", 32'(pulses), 32'd0);
    chk("midrst_no_bus", 32'(wrs), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_controller.md
Name: data_mem_controller

Overview:
- Responder end of the LSB↔dcache request interface.
- Accepts one load/store request at a time from the load-store buffer and serialises it onto the byte-wide external memory/IO bus (one byte per cycle, little-endian).
- Returns load data, sign/zero-extended, together with a one-cycle completion pulse.
- Sits between the load-store buffer and the memory arbiter.

Parameters:
- ADDR_WIDTH, 18, width of request and memory addresses.
- IO_TAG, 2'b11, value of addr[ADDR_WIDTH-1:ADDR_WIDTH-2] that marks the IO space.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- dcache_rw_en  in  1  request valid.
- dcache_write_mode  in  1  1 = store, 0 = load.
- dcache_width  in  2  0 = byte, 1 = half, 2 = word.
- dcache_sign_ext  in  1  load sign-extend flag.
- dcache_addr  in  ADDR_WIDTH  byte address.
- dcache_value  in  32  store data.
- dcache_idle  out  1  controller free (state IDLE).
- dcache_rw_feedback_en  out  1  one-cycle completion pulse.
- dcache_load_val  out  32  extended load result; valid only with feedback.
- mem_busy  out  1  request to the arbiter: bus needed or in use.
- mem_grant  in  1  arbiter grant.
- mem_din  in  8  read byte; valid the cycle after its address was driven.
- mem_dout  out  8  write byte.
- mem_a  out  ADDR_WIDTH  bus address.
- mem_wr  out  1  write strobe.
- io_buffer_full  in  1  IO sink cannot take a write this cycle.

Behaviour:
- Reset values: state=IDLE; dcache_idle=1, feedback_en=0, load_val=0, mem_busy=0, mem_wr=0, mem_a=0, mem_dout=0.
- Reset mid-operation abandons the op: no feedback, no further bytes driven.
- States: IDLE, GNT, RD, WR.
- Acceptance: the request is sampled at an edge where dcache_rw_en=1 and (state==IDLE or dcache_rw_feedback_en==1).
  - Back-to-back: a request issued in the feedback cycle must be accepted.
  - Acceptance latches mode, width, sign_ext, addr and value; byte count N = 1/2/4.
  - Width 2'b11 is illegal: $fatal in simulation, treated as word.
- mem_busy=1 in every state except IDLE.
- GNT: entered on accept.
  - Bus is driven only when mem_grant=1.
  - If mem_grant=0: mem_wr=0, mem_a=0, stay in GNT.
  - The arbiter holds grant while mem_busy=1, so grant is checked only here.
  - In a GNT cycle with grant, byte 0 is issued and the state moves to RD or WR.
- Load (GNT→RD): the cycle that issues byte k drives mem_a = addr+k, mem_wr=0, for k = 0..N-1 on consecutive cycles.
  - mem_din is captured one cycle after each address, into byte lane k.
  - When the last byte is captured (edge E), dcache_load_val and feedback_en=1 are registered and visible in the cycle after E.
  - Example: word load accepted at E0, granted immediately → addresses in cycles 1–4, bytes captured at E2–E5, feedback in cycle 6.
  - Example: byte load → feedback in cycle 3.
- Extension: byte/half are sign-extended from bit 7/15 when sign_ext=1, otherwise zero-extended. Word is passed through.
- Store (GNT→WR): in each cycle issuing byte k, mem_a = addr+k, mem_dout = value[8k+7:8k], mem_wr=1.
  - Feedback is asserted in the cycle after the last byte.
  - Word store unstalled: bytes in cycles 1–4, feedback in cycle 5.
- IO stall: if the addr tag equals IO_TAG, the op is a store and io_buffer_full=1 in a cycle, drive mem_wr=0, do not advance k, and retry next cycle.
  - Loads are never stalled by io_buffer_full.
- Addresses: addr+k wraps modulo 2^ADDR_WIDTH. No alignment requirement.
- Feedback cycle: state returns to IDLE, or moves to GNT if a new request is accepted.
  - dcache_idle=0 during feedback; the LSB relies on the feedback-cycle acceptance rule.
- Bus defaults: in any cycle where mem_wr=0, mem_dout=0.

Test Plan:
- Word load at addr 0x00100; memory bytes 0x11,0x22,0x33,0x84; grant=1 → mem_a 0x100..0x103 in cycles 1–4; feedback cycle 6; load_val=0x84332211.
- Byte load at 0x00200 (byte 0x80), sign_ext=1, then sign_ext=0 → 0xFFFFFF80 then 0x00000080; feedback 3 cycles after acceptance.
- Half store value 0xABCD1234 at 0x3FFFF → (0x3FFFF,0x34), (0x00000,0x12) with mem_wr=1; feedback cycle 3.
- IO byte store 0x41 to 0x30000 with io_buffer_full high for 3 cycles → mem_wr=0 for those 3 cycles; single write of 0x41 after; exactly one feedback.
- Back-to-back: load issued with rw_en held so a second word store is presented in the feedback cycle → accepted with no idle gap; mem_busy stays 1.
- mem_grant low for 5 cycles after accept → no bus activity; all timing shifts by 5. rst asserted mid word load → idle=1, busy=0, no feedback.
